stopwatch_counter: RTL
======================

Name: stopwatch_counter

Overview:
Downstream datapath stage of the stopwatch; consumes the mode state produced by the mode FSM (IDLE/RUNNING/CLEAR) and keeps elapsed time in BCD as MM:SS.CC. Counts centiseconds while RUNNING, holds while IDLE and zeroes on CLEAR. Supports a lap-freeze display. Drives six seven-segment digits (ss5..ss0) on the FPGA top level.

Parameters:
TICK_DIV, 1, clk cycles per centisecond (1 for hz100; must be >= 1)

Ports:
clk  input  1  system clock (hz100 on the board)
rst  input  1  asynchronous, active-high reset
mode  input  3  state_t from mode FSM: IDLE=3'b100, RUNNING=3'b001, CLEAR=3'b010
lap_req  input  1  single-cycle pulse; toggles lap freeze
time_bcd  output  24  live count {min_t, min_o, sec_t, sec_o, cs_t, cs_o}, 4 bits each
disp_bcd  output  24  displayed value: time_bcd, or the frozen lap value
lap_active  output  1  display frozen
wrap  output  1  one-cycle pulse on rollover 59:59.99 -> 00:00.00
mode_err  output  1  high while mode is not a legal one-hot encoding
ss5..ss0  output  8 each  segment patterns of disp_bcd; bit0=a..bit6=g, bit7=dp

Behaviour:
- Reset (async): time_bcd=0, disp_bcd=0, lap register=0, prescaler=0, lap_active=0, wrap=0. mode_err is combinational from mode; all segment outputs show "00.00.00" (dp lit on ss4 and ss2).
- Prescaler: 0..TICK_DIV-1. Advances only when mode==RUNNING. A tick occurs on the edge where it equals TICK_DIV-1; it then returns to 0. With TICK_DIV=1, every RUNNING cycle is a tick.
- Tick: increment cs_o. Carry chain: cs_o 9->0 carries to cs_t; cs_t 9->0 carries to sec_o; sec_o 9->0 carries to sec_t; sec_t 5->0 carries to min_o; min_o 9->0 carries to min_t; min_t 5->0.
- Full rollover 59:59.99 -> 00:00.00: wrap=1 for exactly that cycle; counting continues.
- Latency: the new count is visible on time_bcd in the cycle after the tick edge.
- IDLE: time and prescaler hold (pause). Resuming RUNNING continues from the held prescaler value.
- CLEAR: on each edge while in CLEAR, synchronously set time=0, prescaler=0, lap_active=0; wrap=0.
- Illegal mode (any value other than the three codes): behaves as IDLE (hold); mode_err=1.
- Lap:
  - lap_req with lap_active=0 captures the current time_bcd (pre-increment value on that edge) into the lap register and sets lap_active=1.
  - lap_req with lap_active=1 clears lap_active.
  - Accepted in RUNNING and IDLE. Ignored in CLEAR, where CLEAR wins.
- disp_bcd = lap_active ? lap register : time_bcd.
- Segments: combinational from disp_bcd. BCD 0-9 use standard active-high patterns; non-BCD values blank. dp (bit7) is 1 only on ss4 and ss2.
- No state change except on clk edge; rst mid-count returns everything to reset values immediately.

Decomposition:
- Shared package stopwatch_pkg:
  - state_t enum, with IDLE/RUNNING/CLEAR codes, moved out of the top-level file.
  - SEG_* digit pattern constants and SEG_BLANK.
  - Digit limits CS_MAX=9/9, SEC_TENS_MAX=5, MIN_TENS_MAX=5.
- One sub-module bcd_to_7seg: 4-bit in, 7-bit out, combinational. Instantiated six times; dp is appended in the parent.

Test Plan:
- Reset, mode=RUNNING for 150 cycles (TICK_DIV=1) -> time_bcd=00:01.50 (24'h000150); ss2=SEG_1|dp.
- RUNNING 123 cycles, IDLE 50 cycles, RUNNING 77 cycles -> 00:02.00; value constant throughout IDLE.
- Preload via 359999 RUNNING cycles to 59:59.99, one more tick -> 00:00.00 and wrap=1 for one cycle only.
- RUNNING to 00:00.40, lap_req pulse -> lap_active=1, disp_bcd frozen at 000040 while time_bcd continues. After 60 more cycles, second lap_req -> disp_bcd=000100 next cycle.
- lap_active=1 and CLEAR asserted with lap_req in the same cycle -> time=0, lap_active=0, disp_bcd=0.
- mode=3'b011 during RUNNING -> count holds, mode_err=1. TICK_DIV=4 build: 8 RUNNING cycles -> 00:00.02. Async rst asserted mid-cycle -> all outputs zero before the next edge.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared types, seven-segment patterns and digit limits for the stopwatch datapath.
package stopwatch_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'b100,
    RUNNING = 3'b001,
    CLEAR   = 3'b010
  } state_t;

  typedef struct packed {
    logic [3:0] min_t;
    logic [3:0] min_o;
    logic [3:0] sec_t;
    logic [3:0] sec_o;
    logic [3:0] cs_t;
    logic [3:0] cs_o;
  } bcd_time_t;

  // Active-high segment patterns, bit0 = a .. bit6 = g.
  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  localparam logic [3:0] CS_MAX       = 4'd9;
  localparam logic [3:0] ONES_MAX     = 4'd9;
  localparam logic [3:0] SEC_TENS_MAX = 4'd5;
  localparam logic [3:0] MIN_TENS_MAX = 4'd5;

  // Returns {carry_out, next_digit}; a disabled stage passes its digit through.
  function automatic logic [4:0] digit_step(input logic [3:0] digit, input logic [3:0] max,
                                            input logic en);
    if (!en) return {1'b0, digit};
    if (digit >= max) return {1'b1, 4'd0};
    return {1'b0, digit + 4'd1};
  endfunction

  function automatic logic mode_legal(input logic [2:0] m);
    return (m == IDLE) || (m == RUNNING) || (m == CLEAR);
  endfunction

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD digit to seven-segment decoder; non-BCD codes blank the digit.
module bcd_to_7seg
  import stopwatch_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/stopwatch_counter.sv
// Stopwatch datapath: BCD MM:SS.CC counter driven by the mode FSM, with lap freeze
// and six seven-segment digit outputs.
module stopwatch_counter
  import stopwatch_pkg::*;
#(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  mode,
  input  logic        lap_req,
  output logic [23:0] time_bcd,
  output logic [23:0] disp_bcd,
  output logic        lap_active,
  output logic        wrap,
  output logic        mode_err,
  output logic [7:0]  ss5,
  output logic [7:0]  ss4,
  output logic [7:0]  ss3,
  output logic [7:0]  ss2,
  output logic [7:0]  ss1,
  output logic [7:0]  ss0
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
  // Decimal points separate MM.SS.CC: lit on ss4 and ss2.
  localparam logic [5:0] DP_MASK = 6'b010100;

  logic [PW-1:0] pre_q, pre_d;
  logic [23:0]   time_q, time_d;
  logic [23:0]   lap_q, lap_d;
  logic          lap_active_q, lap_active_d;
  logic          wrap_q, wrap_d;

  logic          is_run, is_clear, tick;
  bcd_time_t     cur, nxt;
  logic          c_cs_t, c_sec_o, c_sec_t, c_min_o, c_min_t, rollover;

  assign is_run   = (mode == RUNNING);
  assign is_clear = (mode == CLEAR);
  assign tick     = is_run && (pre_q == PRE_LAST);
  assign cur      = time_q;

  always_comb begin
    nxt = cur;
    {c_cs_t,   nxt.cs_o}  = digit_step(cur.cs_o,  CS_MAX,       tick);
    {c_sec_o,  nxt.cs_t}  = digit_step(cur.cs_t,  CS_MAX,       c_cs_t);
    {c_sec_t,  nxt.sec_o} = digit_step(cur.sec_o, ONES_MAX,     c_sec_o);
    {c_min_o,  nxt.sec_t} = digit_step(cur.sec_t, SEC_TENS_MAX, c_sec_t);
    {c_min_t,  nxt.min_o} = digit_step(cur.min_o, ONES_MAX,     c_min_o);
    {rollover, nxt.min_t} = digit_step(cur.min_t, MIN_TENS_MAX, c_min_t);
  end

  // Illegal mode codes fall through as IDLE: nothing advances, laps still accepted.
  always_comb begin
    pre_d        = pre_q;
    time_d       = time_q;
    lap_d        = lap_q;
    lap_active_d = lap_active_q;
    wrap_d       = 1'b0;
    if (is_clear) begin
      pre_d        = '0;
      time_d       = '0;
      lap_active_d = 1'b0;
    end else begin
      if (is_run) begin
        pre_d = tick ? '0 : pre_q + PW'(1);
      end
      if (tick) begin
        time_d = nxt;
        wrap_d = rollover;
      end
      if (lap_req) begin
        if (lap_active_q) begin
          lap_active_d = 1'b0;
        end else begin
          lap_d        = time_q;
          lap_active_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_q        <= '0;
      time_q       <= '0;
      lap_q        <= '0;
      lap_active_q <= 1'b0;
      wrap_q       <= 1'b0;
    end else begin
      pre_q        <= pre_d;
      time_q       <= time_d;
      lap_q        <= lap_d;
      lap_active_q <= lap_active_d;
      wrap_q       <= wrap_d;
    end
  end

  assign time_bcd   = time_q;
  assign disp_bcd   = lap_active_q ? lap_q : time_q;
  assign lap_active = lap_active_q;
  assign wrap       = wrap_q;
  assign mode_err   = ~mode_legal(mode);

  logic [6:0] seg [6];

  for (genvar i = 0; i < 6; i++) begin : g_digit
    bcd_to_7seg u_dec (
      .bcd (disp_bcd[4*i +: 4]),
      .seg (seg[i])
    );
  end

  assign ss0 = {DP_MASK[0], seg[0]};
  assign ss1 = {DP_MASK[1], seg[1]};
  assign ss2 = {DP_MASK[2], seg[2]};
  assign ss3 = {DP_MASK[3], seg[3]};
  assign ss4 = {DP_MASK[4], seg[4]};
  assign ss5 = {DP_MASK[5], seg[5]};

  // A rollover pulse always coincides with a zeroed count.
  a_wrap_zero : assert property (@(posedge clk) disable iff (rst) wrap |-> time_bcd == '0);
  // CLEAR overrides any lap request on the same edge.
  a_clear_lap : assert property (@(posedge clk) disable iff (rst) is_clear |=> !lap_active);

endmodule
